// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants for the instruction fetch unit.
// Default parameter values, instruction size, PC step, sign-extend width.
package ifu_pkg;
   localparam int          DEF_ADDR_W   = 32;
   localparam int          DEF_DATA_W   = 32;
   localparam int          DEF_IM_DEPTH = 1024;
   localparam int          DEF_FQ_DEPTH = 4;
   localparam int unsigned DEF_RESET_PC = 0;
   localparam int          INSTR_BYTES  = 4;
   localparam int          PC_INC       = 4;
   localparam int          SE_SRC_W     = 16;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {pc, instruction} entries.
// Ports: push/push_data, pop, flush (clears all), head, count.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] rp;
   logic [PW-1:0] wp;

   assign head = store[rp];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else if (flush) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else begin
         if (push)
            wp <= wp + PW'(1);
         if (pop)
            rp <= rp + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Payload needs no reset; the top gates the head with valid.
   always_ff @(posedge clk) begin
      if (push && !flush)
         store[wp] <= push_data;
   end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, word memory with load port, fetch queue.
// Ports: fetch_en/redirect in, ld_* load port, inst_* head out, fq_count.
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int IM_DEPTH = DEF_IM_DEPTH,
   parameter int FQ_DEPTH = DEF_FQ_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      fetch_en,
   input  logic                      redirect,
   input  logic [ADDR_W-1:0]         redirect_pc,
   input  logic                      ld_en,
   input  logic [ADDR_W-1:0]         ld_addr,
   input  logic [DATA_W-1:0]         ld_data,
   input  logic                      inst_ready,
   output logic                      inst_valid,
   output logic [DATA_W-1:0]         inst,
   output logic [ADDR_W-1:0]         inst_pc,
   output logic [DATA_W-1:0]         se_16,
   output logic [$clog2(FQ_DEPTH):0] fq_count
);
   localparam int CW = $clog2(FQ_DEPTH) + 1;
   localparam int IW = $clog2(IM_DEPTH);
   localparam int QW = DATA_W + ADDR_W;
   localparam int SH = $clog2(INSTR_BYTES);
   localparam logic [CW:0] FQ_LIM = (CW+1)'(FQ_DEPTH);
   localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(INSTR_BYTES - 1);

   logic [DATA_W-1:0] imem [IM_DEPTH];
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] rd_pc;
   logic [DATA_W-1:0] rd_data;
   logic              in_flight;
   logic              issue;
   logic              push;
   logic              pop;
   logic [CW:0]       occupancy;
   logic [QW-1:0]     head;
   logic [DATA_W-1:0] head_inst;
   logic [ADDR_W-1:0] head_pc;

   function automatic logic [IW-1:0] word_idx(
      input logic [ADDR_W-1:0] a
   );
      return IW'((a >> SH) % ADDR_W'(IM_DEPTH));
   endfunction

   // An in-flight read already owns a queue slot, so pushes never overflow.
   assign occupancy = {1'b0, fq_count} + (CW+1)'(in_flight);
   assign issue     = fetch_en && !redirect && (occupancy < FQ_LIM);
   assign push      = in_flight && !redirect;
   assign inst_valid = (fq_count != '0);
   assign pop       = inst_valid && inst_ready;

   assign {head_pc, head_inst} = head;
   assign inst    = inst_valid ? head_inst : '0;
   assign inst_pc = inst_valid ? head_pc : '0;
   assign se_16   = {{(DATA_W-SE_SRC_W){inst[SE_SRC_W-1]}},
                     inst[SE_SRC_W-1:0]};

   // Nonblocking read and write give read-before-write on a collision.
   always_ff @(posedge clk) begin
      if (issue)
         rd_data <= imem[word_idx(pc)];
      if (ld_en)
         imem[word_idx(ld_addr)] <= ld_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc        <= RESET_PC;
         rd_pc     <= '0;
         in_flight <= 1'b0;
      end else if (redirect) begin
         pc        <= redirect_pc & ALIGN;
         in_flight <= 1'b0;
      end else begin
         in_flight <= issue;
         if (issue) begin
            rd_pc <= pc;
            pc    <= pc + ADDR_W'(PC_INC);
         end
      end
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH),
      .W     (QW)
   ) u_fq (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({rd_pc, rd_data}),
      .pop       (pop),
      .flush     (redirect),
      .head      (head),
      .count     (fq_count)
   );
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The parameter list SHALL be:
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.
- IM_DEPTH, 1024, instruction memory depth in words.
- FQ_DEPTH, 4, fetch-queue entries; power of two, at least 2.
- RESET_PC, 0, PC value after reset.

REQ-002 The port list SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- fetch_en, in, 1, permits new fetches.
- redirect, in, 1, branch/jump: flush and restart at redirect_pc.
- redirect_pc, in, ADDR_W, new fetch address.
- ld_en, in, 1, memory load-port write strobe.
- ld_addr, in, ADDR_W, byte address for the load port.
- ld_data, in, DATA_W, word written by the load port.
- inst_ready, in, 1, consumer accepts the queue head.
- inst_valid, out, 1, queue head holds a valid instruction.
- inst, out, DATA_W, instruction at the queue head.
- inst_pc, out, ADDR_W, PC of the head instruction.
- se_16, out, DATA_W, inst[15:0] sign-extended to DATA_W.
- fq_count, out, clog2(FQ_DEPTH)+1, occupied queue entries.

Function
REQ-003 Memory SHALL be word-organised with synchronous read and 1-cycle latency; word index = address[ADDR_W-1:2] modulo IM_DEPTH.
REQ-004 A fetch SHALL issue in a cycle where fetch_en=1, redirect=0, and fq_count + in_flight < FQ_DEPTH.
REQ-005 Each issued fetch SHALL advance the PC by 4, wrapping modulo 2^ADDR_W.
REQ-006 Read data SHALL be pushed into the queue together with its PC on the edge after issue.
REQ-007 The first instruction SHALL reach the queue head with inst_valid=1 two edges after the first issue.
REQ-008 With fetch_en=1 and inst_ready held at 1, throughput SHALL be one instruction per cycle.
REQ-009 inst_valid SHALL equal (fq_count != 0); a pop SHALL occur exactly when inst_valid=1 and inst_ready=1.
REQ-010 inst, inst_pc and se_16 SHALL be held stable while inst_valid=1 and inst_ready=0.
REQ-011 A push and a pop in the same cycle SHALL leave fq_count unchanged, including when the queue is full.
REQ-012 A push SHALL never be dropped, because the issue rule (REQ-004) reserves a slot for every in-flight read.
REQ-013 On redirect=1 the next edge SHALL:
- empty the queue;
- discard any in-flight read;
- load the PC with {redirect_pc[ADDR_W-1:2], 2'b00}.
REQ-014 In the cycle after a redirect, inst_valid SHALL be 0 and the first fetch from the new PC SHALL issue, provided fetch_en=1.
REQ-015 A redirect coinciding with a valid/ready handshake SHALL count the handshake as completed and then apply the flush.
REQ-016 When fetch_en=0 no fetch SHALL issue; an in-flight read SHALL still complete and queued entries SHALL remain poppable.
REQ-017 ld_en=1 SHALL write ld_data to word ld_addr[ADDR_W-1:2] mod IM_DEPTH; the load port is independent of fetch_en.
REQ-018 A same-cycle write and fetch to the same word SHALL return the old data (read-before-write).
REQ-019 se_16 SHALL equal {(DATA_W-16) copies of inst[15], inst[15:0]}.

Reset
REQ-020 While reset=0, regardless of clk, the block SHALL force:
- PC = RESET_PC;
- queue empty, in-flight flag cleared;
- fq_count = 0, inst_valid = 0;
- inst, inst_pc and se_16 = 0.
REQ-021 Memory contents SHALL NOT be cleared by reset.
REQ-022 Reset asserted mid-operation SHALL abandon any in-flight read; its data SHALL never be pushed.
REQ-023 The first fetch after reset release SHALL use RESET_PC.

Structure
REQ-024 Shared package ifu_pkg SHALL hold:
- the default parameter values;
- INSTR_BYTES = 4;
- PC_INC = 4;
- SE_SRC_W = 16.
REQ-025 The queue SHALL be a separate sub-module, fetch_queue, parameterised by depth and entry width (DATA_W+ADDR_W), with push, pop, flush and count.
REQ-026 The memory array and PC logic SHALL reside in instruction_fetch_unit.

Verification
REQ-027 The bench SHALL cover at least these directed scenarios:
- Words 0..7 preloaded with 0x1000_0000+i, fetch_en=1, inst_ready=1 -> inst_valid rises two edges after the first issue; inst_pc sequence 0,4,8,...; one instruction per cycle.
- inst_ready=0 for 10 cycles -> fq_count saturates at 4, PC stops at 0x10, head stays 0x1000_0000; inst_ready=1 -> four back-to-back pops with no gap.
- redirect with redirect_pc=0x0000_0023 while the queue is full -> next cycle fq_count=0 and inst_valid=0; next head has inst_pc=0x20.
- Word 0 = 0x0000_8001 -> se_16=0xFFFF_8001; word 0 = 0x0000_7FFF -> se_16=0x0000_7FFF.
- With IM_DEPTH=1024, fetch from PC 0xFFC then 0x1000 -> word 1023 then word 0; PC 0xFFFF_FFFC increments to 0x0.
- reset=0 asynchronously mid-stream with 2 entries queued -> all outputs 0 at once; after release the first inst_pc = RESET_PC.
